merlin_bus_arbiter32: RTL and testbench

//  Shares one 32-bit memory bus between the pre-fetch unit (I-side) and the load/store unit (D-side).

---
 rtl/merlin_bus_arbiter32_pkg.sv | 17 +
 rtl/merlin_bus_arbiter32_fifo.sv | 84 ++++++++
 rtl/merlin_bus_arbiter32.sv | 152 +++++++++++++++
 tb/tb_merlin_bus_arbiter32.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merlin_bus_arbiter32_pkg.sv
// Shared definitions for the merlin I/D bus arbiter.
// Source tags, bus size codes and the request bundle.
package merlin_bus_arbiter32_pkg;

  localparam logic       RV_BUS_SRC_I     = 1'b0;
  localparam logic       RV_BUS_SRC_D     = 1'b1;
  localparam logic [1:0] RV_BUS_SIZE_WORD = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  hpl;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] data;
  } bus_req_t;

endpackage

// File: rtl/merlin_bus_arbiter32_fifo.sv
// Small synchronous FIFO holding response-routing tags.
// Push is ignored when full, pop is ignored when empty.
module merlin_bus_arbiter32_fifo #(
  parameter int C_FIFO_WIDTH       = 1,
  parameter int C_FIFO_DEPTH_X     = 2,
  parameter int C_FIFO_PASSTHROUGH = 0
) (
  input  logic                    clk_i,
  input  logic                    resetb_i,
  input  logic                    clk_en_i,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [C_FIFO_WIDTH-1:0] data_i,
  input  logic                    pop_i,
  output logic [C_FIFO_WIDTH-1:0] data_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int DEPTH = 1 << C_FIFO_DEPTH_X;
  localparam int PW    = C_FIFO_DEPTH_X;
  localparam logic [PW:0]   LVL_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   LVL_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [C_FIFO_WIDTH-1:0] mem_q [DEPTH];
  logic [C_FIFO_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_q == LVL_FULL);
  assign empty_o = (level_q == '0);
  assign do_push = clk_en_i & push_i & ~full_o;
  assign do_pop  = clk_en_i & pop_i & ~empty_o;

  assign data_o = ((C_FIFO_PASSTHROUGH != 0) && empty_o)
                ? data_i : mem_q[rd_ptr_q];

  // Pointer, level and storage next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_ONE;
    end else if (do_pop && !do_push) begin
      level_d = level_q - LVL_ONE;
    end
    if (clk_en_i && flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/merlin_bus_arbiter32.sv
// Shares one 32-bit bus between the pre-fetch (I) and load/store (D) units.
// Zero-latency request mux, stable stalled grants, tag FIFO for responses.
module merlin_bus_arbiter32
  import merlin_bus_arbiter32_pkg::*;
#(
  parameter int C_OUTSTANDING_X = 2,
  parameter int C_STARVE_LIMIT  = 4
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  input  logic        ireqvalid_i,
  output logic        ireqready_o,
  input  logic [31:0] ireqaddr_i,
  input  logic [1:0]  ireqhpl_i,
  output logic        irspvalid_o,
  input  logic        irspready_i,
  output logic        irsprerr_o,
  output logic [31:0] irspdata_o,
  input  logic        dreqvalid_i,
  output logic        dreqready_o,
  input  logic [31:0] dreqaddr_i,
  input  logic [1:0]  dreqhpl_i,
  input  logic        dreqwr_i,
  input  logic [1:0]  dreqsize_i,
  input  logic [31:0] dreqdata_i,
  output logic        drspvalid_o,
  input  logic        drspready_i,
  output logic        drsprerr_o,
  output logic [31:0] drspdata_o,
  output logic        breqvalid_o,
  input  logic        breqready_i,
  output logic [31:0] breqaddr_o,
  output logic [1:0]  breqhpl_o,
  output logic        breqwr_o,
  output logic [1:0]  breqsize_o,
  output logic [31:0] breqdata_o,
  input  logic        brspvalid_i,
  output logic        brspready_o,
  input  logic        brsprerr_i,
  input  logic [31:0] brspdata_i
);

  localparam logic [3:0] STARVE_LIM = 4'(C_STARVE_LIMIT);

  logic       hold_q, hold_d;
  logic       held_src_q, held_src_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       win_src;
  logic       held_valid;
  logic       starved;
  logic       grant_ok;
  logic       req_acc;
  logic       rsp_pop;
  logic       rsp_is_d;
  logic       tag_full;
  logic       tag_empty;
  logic       tag_head;
  bus_req_t   win_req;

  assign held_valid = held_src_q ? dreqvalid_i : ireqvalid_i;
  assign starved    = ireqvalid_i && (starve_cnt_q == STARVE_LIM);

  // Winner select: a live held grant first, then D unless I is starved.
  always_comb begin
    win_src = RV_BUS_SRC_I;
    if (hold_q && held_valid) begin
      win_src = held_src_q;
    end else if (dreqvalid_i && !starved) begin
      win_src = RV_BUS_SRC_D;
    end
  end

  // Request mux; the I side always issues word reads.
  always_comb begin
    win_req = '{addr: ireqaddr_i, hpl: ireqhpl_i, wr: 1'b0,
                size: RV_BUS_SIZE_WORD, data: 32'h0};
    if (win_src == RV_BUS_SRC_D) begin
      win_req = '{addr: dreqaddr_i, hpl: dreqhpl_i, wr: dreqwr_i,
                  size: dreqsize_i, data: dreqdata_i};
    end
  end

  assign breqaddr_o  = win_req.addr;
  assign breqhpl_o   = win_req.hpl;
  assign breqwr_o    = win_req.wr;
  assign breqsize_o  = win_req.size;
  assign breqdata_o  = win_req.data;
  assign breqvalid_o = (ireqvalid_i | dreqvalid_i) & ~tag_full;
  assign grant_ok    = breqready_i & ~tag_full;
  assign ireqready_o = (win_src == RV_BUS_SRC_I) & grant_ok;
  assign dreqready_o = (win_src == RV_BUS_SRC_D) & grant_ok;
  assign req_acc     = breqvalid_o & breqready_i & clk_en_i;

  // Hold and starvation counter next-state.
  always_comb begin
    hold_d       = hold_q;
    held_src_d   = held_src_q;
    starve_cnt_d = starve_cnt_q;
    if (clk_en_i) begin
      hold_d     = breqvalid_o & ~breqready_i;
      held_src_d = win_src;
      if (!ireqvalid_i || (req_acc && win_src == RV_BUS_SRC_I)) begin
        starve_cnt_d = '0;
      end else if (req_acc && starve_cnt_q != STARVE_LIM) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      hold_q       <= 1'b0;
      held_src_q   <= RV_BUS_SRC_I;
      starve_cnt_q <= '0;
    end else begin
      hold_q       <= hold_d;
      held_src_q   <= held_src_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign rsp_is_d    = (tag_head == RV_BUS_SRC_D);
  assign irspvalid_o = brspvalid_i & ~tag_empty & ~rsp_is_d;
  assign drspvalid_o = brspvalid_i & ~tag_empty & rsp_is_d;
  assign brspready_o = tag_empty ? brspvalid_i
                     : (rsp_is_d ? drspready_i : irspready_i);
  assign rsp_pop     = brspvalid_i & brspready_o & ~tag_empty;
  assign irsprerr_o  = brsprerr_i;
  assign drsprerr_o  = brsprerr_i;
  assign irspdata_o  = brspdata_i;
  assign drspdata_o  = brspdata_i;

  merlin_bus_arbiter32_fifo #(
    .C_FIFO_WIDTH       (1),
    .C_FIFO_DEPTH_X     (C_OUTSTANDING_X),
    .C_FIFO_PASSTHROUGH (0)
  ) u_tag_fifo (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .clk_en_i (clk_en_i),
    .flush_i  (1'b0),
    .push_i   (req_acc),
    .data_i   (win_src),
    .pop_i    (rsp_pop),
    .data_o   (tag_head),
    .full_o   (tag_full),
    .empty_o  (tag_empty)
  );

endmodule

// File: tb/tb_merlin_bus_arbiter32.sv
// Self-checking bench for merlin_bus_arbiter32.
// Directed scenarios followed by random traffic against a queue model.
module tb_merlin_bus_arbiter32;

  logic        clk;
  logic        resetb;
  logic        clk_en;
  logic        ireqvalid, ireqready;
  logic [31:0] ireqaddr;
  logic [1:0]  ireqhpl;
  logic        irspvalid, irspready, irsprerr;
  logic [31:0] irspdata;
  logic        dreqvalid, dreqready;
  logic [31:0] dreqaddr;
  logic [1:0]  dreqhpl;
  logic        dreqwr;
  logic [1:0]  dreqsize;
  logic [31:0] dreqdata;
  logic        drspvalid, drspready, drsprerr;
  logic [31:0] drspdata;
  logic        breqvalid, breqready;
  logic [31:0] breqaddr;
  logic [1:0]  breqhpl;
  logic        breqwr;
  logic [1:0]  breqsize;
  logic [31:0] breqdata;
  logic        brspvalid, brspready, brsprerr;
  logic [31:0] brspdata;

  int errs;
  int checks;

  merlin_bus_arbiter32 #(
    .C_OUTSTANDING_X (2),
    .C_STARVE_LIMIT  (4)
  ) dut (
    .clk_i       (clk),
    .resetb_i    (resetb),
    .clk_en_i    (clk_en),
    .ireqvalid_i (ireqvalid),
    .ireqready_o (ireqready),
    .ireqaddr_i  (ireqaddr),
    .ireqhpl_i   (ireqhpl),
    .irspvalid_o (irspvalid),
    .irspready_i (irspready),
    .irsprerr_o  (irsprerr),
    .irspdata_o  (irspdata),
    .dreqvalid_i (dreqvalid),
    .dreqready_o (dreqready),
    .dreqaddr_i  (dreqaddr),
    .dreqhpl_i   (dreqhpl),
    .dreqwr_i    (dreqwr),
    .dreqsize_i  (dreqsize),
    .dreqdata_i  (dreqdata),
    .drspvalid_o (drspvalid),
    .drspready_i (drspready),
    .drsprerr_o  (drsprerr),
    .drspdata_o  (drspdata),
    .breqvalid_o (breqvalid),
    .breqready_i (breqready),
    .breqaddr_o  (breqaddr),
    .breqhpl_o   (breqhpl),
    .breqwr_o    (breqwr),
    .breqsize_o  (breqsize),
    .breqdata_o  (breqdata),
    .brspvalid_i (brspvalid),
    .brspready_o (brspready),
    .brsprerr_i  (brsprerr),
    .brspdata_i  (brspdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Model state for the random phase.
  bit mq[$];
  int starve;
  bit mhold;
  bit mheld;

  initial begin
    bit exp_order [10];
    errs = 0;
    checks = 0;
    resetb = 1'b0; clk_en = 1'b1;
    ireqvalid = 0; ireqaddr = 0; ireqhpl = 0; irspready = 0;
    dreqvalid = 0; dreqaddr = 0; dreqhpl = 0; dreqwr = 0;
    dreqsize = 2'b10; dreqdata = 0; drspready = 0;
    breqready = 0; brspvalid = 0; brsprerr = 0; brspdata = 0;

    // 1: reset state
    tick(); settle();
    chk("rst_breqvalid", breqvalid, 0);
    tick();
    resetb = 1'b1;
    tick(); settle();
    chk("t1_breqvalid", breqvalid, 0);
    chk("t1_irspvalid", irspvalid, 0);
    chk("t1_drspvalid", drspvalid, 0);
    chk("t1_brspready", brspready, 0);

    // 2: D wins the tie, response routed to D
    ireqvalid = 1; ireqaddr = 32'h200;
    dreqvalid = 1; dreqaddr = 32'h100; breqready = 1;
    settle();
    chk("t2_addr", breqaddr, 32'h100);
    chk("t2_dready", dreqready, 1);
    chk("t2_iready", ireqready, 0);
    tick();
    ireqvalid = 0; dreqvalid = 0; breqready = 0;
    brspvalid = 1; brspdata = 32'hCAFE0000; drspready = 1;
    settle();
    chk("t2_drspvalid", drspvalid, 1);
    chk("t2_irspvalid", irspvalid, 0);
    chk("t2_drspdata", drspdata, 32'hCAFE0000);
    chk("t2_brspready", brspready, 1);
    tick();
    brspvalid = 0; drspready = 0;

    // 3: stalled I grant stays stable when D arrives
    ireqvalid = 1; ireqaddr = 32'h300; breqready = 0;
    settle();
    chk("t3_c1_addr", breqaddr, 32'h300);
    tick();
    dreqvalid = 1; dreqaddr = 32'h400;
    settle();
    chk("t3_c2_addr", breqaddr, 32'h300);
    chk("t3_c2_dready", dreqready, 0);
    tick(); settle();
    chk("t3_c3_addr", breqaddr, 32'h300);
    tick();
    breqready = 1;
    settle();
    chk("t3_hs_addr", breqaddr, 32'h300);
    chk("t3_hs_iready", ireqready, 1);
    tick();
    ireqvalid = 0;
    settle();
    chk("t3_d_addr", breqaddr, 32'h400);
    chk("t3_d_ready", dreqready, 1);
    tick();
    dreqvalid = 0;
    brspvalid = 1; irspready = 1; drspready = 1;
    settle();
    chk("t3_rsp0_i", irspvalid, 1);
    tick(); settle();
    chk("t3_rsp1_d", drspvalid, 1);
    tick();
    brspvalid = 0;

    // 4: starvation limit forces I every fifth grant
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    ireqvalid = 1; ireqaddr = 32'h1000;
    dreqvalid = 1; dreqaddr = 32'h2000;
    breqready = 1; brspvalid = 1;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk($sformatf("t4_grant%0d", k), breqaddr,
          exp_order[k] ? 32'h2000 : 32'h1000);
      tick();
    end
    ireqvalid = 0; dreqvalid = 0;
    tick();
    brspvalid = 0;

    // 5: four outstanding fill the tag FIFO, then in-order drain
    for (int k = 0; k < 4; k++) begin
      ireqvalid = (k % 2 == 0);
      dreqvalid = (k % 2 == 1);
      ireqaddr = 32'h10 + 32'(8 * k);
      dreqaddr = 32'h14 + 32'(8 * k);
      settle();
      chk($sformatf("t5_issue%0d", k), breqaddr,
          (k % 2 == 0) ? ireqaddr : dreqaddr);
      tick();
    end
    ireqvalid = 0; dreqvalid = 1; dreqaddr = 32'h20;
    settle();
    chk("t5_full_bvalid", breqvalid, 0);
    chk("t5_full_dready", dreqready, 0);
    tick();
    dreqvalid = 0;
    brspvalid = 1; irspready = 1; drspready = 1;
    for (int k = 0; k < 4; k++) begin
      brspdata = 32'hB0 + 32'(k);
      brsprerr = (k == 2);
      settle();
      chk($sformatf("t5_ivalid%0d", k), irspvalid, (k % 2 == 0));
      chk($sformatf("t5_dvalid%0d", k), drspvalid, (k % 2 == 1));
      if (k == 2) chk("t5_irsprerr", irsprerr, 1);
      tick();
    end
    brsprerr = 0;
    settle();
    chk("t5_empty_bready", brspready, 1);
    chk("t5_empty_irv", irspvalid, 0);
    chk("t5_empty_drv", drspvalid, 0);
    tick();
    brspvalid = 0;

    // 6: stalled I response does not block new D grants
    ireqvalid = 1; ireqaddr = 32'h50;
    tick();
    ireqvalid = 0;
    brspvalid = 1; irspready = 0; drspready = 1;
    dreqvalid = 1; dreqaddr = 32'h60;
    settle();
    chk("t6_irv", irspvalid, 1);
    chk("t6_bready", brspready, 0);
    chk("t6_bvalid", breqvalid, 1);
    chk("t6_dready", dreqready, 1);
    tick();
    dreqvalid = 0;
    settle();
    chk("t6_tag_kept", irspvalid, 1);
    chk("t6_bready2", brspready, 0);
    irspready = 1;
    settle();
    chk("t6_bready3", brspready, 1);
    tick(); settle();
    chk("t6_d_rsp", drspvalid, 1);
    tick();
    brspvalid = 0;

    // Random traffic against a behavioural model
    mq.delete();
    starve = 0; mhold = 0; mheld = 0;
    for (int c = 0; c < 800; c++) begin
      bit iv, dv, br, bv, irr, drr, ce;
      bit full, empty, w, ebv, ebrr, acc, pop;
      iv  = ($urandom_range(0, 3) != 0);
      dv  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 3) != 0);
      bv  = ($urandom_range(0, 1) != 0);
      irr = ($urandom_range(0, 3) != 0);
      drr = ($urandom_range(0, 3) != 0);
      ce  = ($urandom_range(0, 7) != 0);
      ireqvalid = iv; dreqvalid = dv; breqready = br;
      brspvalid = bv; irspready = irr; drspready = drr;
      clk_en = ce;
      ireqaddr = $urandom; dreqaddr = $urandom;
      dreqwr = 1'($urandom); dreqsize = 2'($urandom);
      dreqdata = $urandom; brspdata = $urandom;
      brsprerr = 1'($urandom);
      settle();
      full  = (mq.size() == 4);
      empty = (mq.size() == 0);
      if (mhold && (mheld ? dv : iv)) w = mheld;
      else w = (dv && !(iv && starve == 4));
      ebv = (iv || dv) && !full;
      chk("r_bvalid", breqvalid, ebv);
      if (ebv) begin
        chk("r_addr", breqaddr, w ? dreqaddr : ireqaddr);
        chk("r_wr", breqwr, w ? dreqwr : 1'b0);
        chk("r_size", breqsize, w ? dreqsize : 2'b10);
        chk("r_wdata", breqdata, w ? dreqdata : 32'h0);
        chk("r_iready", ireqready, !w && br);
        chk("r_dready", dreqready, w && br);
      end
      ebrr = empty ? bv : (mq[0] ? drr : irr);
      chk("r_irv", irspvalid, bv && !empty && !mq[0]);
      chk("r_drv", drspvalid, bv && !empty && mq[0]);
      chk("r_bready", brspready, ebrr);
      chk("r_drdata", drspdata, brspdata);
      if (ce) begin
        acc = ebv && br;
        pop = bv && ebrr && !empty;
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(w);
        mhold = ebv && !br;
        mheld = w;
        if (!iv || (acc && !w)) starve = 0;
        else if (acc && starve < 4) starve++;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
